cfu_cmd_sequencer: RTL and testbench

CFU_CMD_SEQUENCER -- requirements
Module: cfu_cmd_sequencer

---
 rtl/cfu_cmd_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_cfu_cmd_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_cmd_sequencer.sv
// cfu_cmd_sequencer: drives a CFU through buffer clear, offset, activation load and per-filter MAC/emit command sequences
module cfu_cmd_sequencer #(
  parameter logic [2:0] FUNCT3_MAC              = 3'd1,
  parameter logic [6:0] FUNCT7_CLEAR            = 7'd1,
  parameter logic [6:0] FUNCT7_SET_OFF          = 7'd2,
  parameter logic [6:0] FUNCT7_SET_INPUT_VALS   = 7'd3,
  parameter logic [6:0] FUNCT7_ON_BUFFER        = 7'd4,
  parameter logic [6:0] FUNCT7_CLEAR_INPUT_VALS = 7'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] cfg_offset,
  input  logic [8:0]  cfg_num_inputs,
  input  logic [7:0]  cfg_num_filters,
  output logic        busy,
  output logic        done,
  input  logic        act_valid,
  output logic        act_ready,
  input  logic [31:0] act_data,
  input  logic        wgt_valid,
  output logic        wgt_ready,
  input  logic [31:0] wgt_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0
);
  typedef enum logic [3:0] {IDLE, CLR_BUF, SET_OFF, LOAD, CLR_ACC, MAC, WAIT_RSP, EMIT, DONE} state_t;
  state_t      state_q, state_d, ret_q, ret_d;
  logic [31:0] off_q, off_d, in0_q, in0_d, in1_q, in1_d, res_data_q, res_data_d;
  logic [8:0]  n_q, n_d, idx_q, idx_d, n_cfg;
  logic [7:0]  f_q, f_d, fidx_q, fidx_d;
  logic [9:0]  fid_q, fid_d;
  logic        busy_q, busy_d, done_q, done_d, cmd_valid_q, cmd_valid_d, res_valid_q, res_valid_d;
  function automatic logic [9:0] fid(input logic [6:0] f7);
    return {f7, FUNCT3_MAC};
  endfunction
  assign n_cfg     = cfg_num_inputs > 9'd256 ? 9'd256 : cfg_num_inputs;
  assign act_ready = state_q == LOAD && !cmd_valid_q;
  assign wgt_ready = state_q == MAC && !cmd_valid_q;
  assign rsp_ready = state_q == WAIT_RSP;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_payload_function_id = fid_q;
  assign cmd_payload_inputs_0    = in0_q;
  assign cmd_payload_inputs_1    = in1_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  // next-state: each command state issues one command, waits for its response, then advances
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    off_d = off_q;
    n_d = n_q;
    f_d = f_q;
    idx_d = idx_q;
    fidx_d = fidx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cmd_valid_d = cmd_valid_q;
    fid_d = fid_q;
    in0_d = in0_q;
    in1_d = in1_q;
    res_valid_d = res_valid_q;
    res_data_d = res_data_q;
    case (state_q)
      IDLE: if (start) begin
        off_d = cfg_offset;
        n_d = n_cfg;
        f_d = cfg_num_filters;
        idx_d = '0;
        fidx_d = '0;
        if (n_cfg == '0 || cfg_num_filters == '0) begin
          state_d = DONE;
          done_d = 1'b1;
        end else begin
          state_d = CLR_BUF;
          busy_d = 1'b1;
          cmd_valid_d = 1'b1;
          fid_d = fid(FUNCT7_CLEAR_INPUT_VALS);
          in0_d = '0;
          in1_d = '0;
        end
      end
      CLR_BUF, SET_OFF, LOAD, CLR_ACC, MAC:
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          ret_d = state_q;
          state_d = WAIT_RSP;
        end else if ((act_ready && act_valid) || (wgt_ready && wgt_valid)) begin
          cmd_valid_d = 1'b1;
          fid_d = act_ready ? fid(FUNCT7_SET_INPUT_VALS) : fid(FUNCT7_ON_BUFFER);
          in0_d = act_ready ? act_data : wgt_data;
          in1_d = '0;
        end
      WAIT_RSP: if (rsp_valid) begin
        case (ret_q)
          CLR_BUF: begin
            state_d = SET_OFF;
            cmd_valid_d = 1'b1;
            fid_d = fid(FUNCT7_SET_OFF);
            in0_d = off_q;
            in1_d = '0;
          end
          SET_OFF: begin
            state_d = LOAD;
            idx_d = '0;
          end
          LOAD: if (idx_q == n_q - 9'd1) begin
            state_d = CLR_ACC;
            fidx_d = '0;
            cmd_valid_d = 1'b1;
            fid_d = fid(FUNCT7_CLEAR);
            in0_d = '0;
            in1_d = '0;
          end else begin
            state_d = LOAD;
            idx_d = idx_q + 9'd1;
          end
          CLR_ACC: begin
            state_d = MAC;
            idx_d = '0;
          end
          default: if (idx_q == n_q - 9'd1) begin
            state_d = EMIT;
            res_valid_d = 1'b1;
            res_data_d = rsp_payload_outputs_0;
          end else begin
            state_d = MAC;
            idx_d = idx_q + 9'd1;
          end
        endcase
      end
      EMIT: if (res_ready) begin
        res_valid_d = 1'b0;
        if (fidx_q == f_q - 8'd1) begin
          state_d = DONE;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          state_d = CLR_ACC;
          fidx_d = fidx_q + 8'd1;
          cmd_valid_d = 1'b1;
          fid_d = fid(FUNCT7_CLEAR);
          in0_d = '0;
          in1_d = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; reset aborts any job, including a pending command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ret_q <= IDLE;
      off_q <= '0;
      n_q <= '0;
      f_q <= '0;
      idx_q <= '0;
      fidx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      fid_q <= '0;
      in0_q <= '0;
      in1_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      off_q <= off_d;
      n_q <= n_d;
      f_q <= f_d;
      idx_q <= idx_d;
      fidx_q <= fidx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cmd_valid_q <= cmd_valid_d;
      fid_q <= fid_d;
      in0_q <= in0_d;
      in1_q <= in1_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
    end
  end
endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// tb_cfu_cmd_sequencer: directed jobs against a CFU responder model with command/result logging
module tb_cfu_cmd_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] cfg_offset = '0;
  logic [8:0] cfg_num_inputs = '0;
  logic [7:0] cfg_num_filters = '0;
  logic busy, done, act_ready, wgt_ready, res_valid, cmd_valid, rsp_ready;
  logic act_valid = 1'b0, wgt_valid = 1'b0, res_ready = 1'b0, cmd_ready = 1'b0, rsp_valid = 1'b0;
  logic [31:0] act_data = '0, wgt_data = '0, rsp_data = '0, res_data, in0, in1;
  logic [9:0] fid;
  int errors = 0, checks = 0;
  int rsp_n = 0, act_n = 0, done_cnt = 0, stab_err = 0, cr_cnt = 0, rd_cnt = 0;
  bit use_tab = 0, rand_dly = 0, hold_onb = 0, res_hold = 0, stray = 0, stray_on = 0;
  bit cmd_fire = 0, rsp_fire = 0, act_fire = 0, res_fire = 0, held = 0, rsp_wait = 0;
  logic [31:0] rsp_tab [8];
  logic [31:0] act_base = '0, wgt_base = '0, c_in0, c_in1, h_in0, h_in1, r_data;
  logic [9:0] c_fid, h_fid;
  logic [9:0] q_fid [$];
  logic [31:0] q_in0 [$], q_in1 [$], q_res [$];

  cfu_cmd_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .cfg_offset(cfg_offset),
    .cfg_num_inputs(cfg_num_inputs), .cfg_num_filters(cfg_num_filters),
    .busy(busy), .done(done),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload_function_id(fid),
    .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // responder, streams and monitor: acts on negedges, handshakes complete on the following posedge
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        cmd_fire = 0; rsp_fire = 0; act_fire = 0; res_fire = 0; held = 0; rsp_wait = 0; stray_on = 0;
        cmd_ready = 0; rsp_valid = 0; act_valid = 0; wgt_valid = 0; res_ready = 0;
      end else begin
        if (cmd_fire) begin
          q_fid.push_back(c_fid); q_in0.push_back(c_in0); q_in1.push_back(c_in1);
          rsp_wait = 1;
          rd_cnt = rand_dly ? int'($urandom_range(0, 5)) : 0;
          cr_cnt = rand_dly ? int'($urandom_range(0, 5)) : 0;
        end
        if (rsp_fire) begin rsp_valid = 0; rsp_n++; end
        if (act_fire) act_n++;
        if (res_fire) q_res.push_back(r_data);
        if (done) done_cnt++;
        if (held && (!cmd_valid || fid !== h_fid || in0 !== h_in0 || in1 !== h_in1)) stab_err++;
        cmd_ready = 0;
        if (cmd_valid && !(hold_onb && fid == 10'h21)) begin
          if (cr_cnt == 0) cmd_ready = 1; else cr_cnt--;
        end
        if (rsp_wait) begin
          if (rd_cnt == 0) begin
            rsp_valid = 1;
            rsp_data = (use_tab && rsp_n < 7) ? rsp_tab[rsp_n[2:0]] : 32'hA000 + 32'(rsp_n);
            rsp_wait = 0;
          end else rd_cnt--;
        end
        if (stray) begin rsp_valid = 1; rsp_data = 32'hDEAD; stray_on = 1; end
        else if (stray_on) begin rsp_valid = 0; stray_on = 0; end
        act_valid = rand_dly ? ($urandom_range(0, 1) == 1) : 1'b1;
        act_data = act_base + 32'(act_n);
        wgt_valid = rand_dly ? ($urandom_range(0, 1) == 1) : 1'b1;
        wgt_data = wgt_base;
        res_ready = !res_hold;
        cmd_fire = cmd_valid && cmd_ready; c_fid = fid; c_in0 = in0; c_in1 = in1;
        held = cmd_valid && !cmd_ready; h_fid = fid; h_in0 = in0; h_in1 = in1;
        rsp_fire = rsp_valid && rsp_ready;
        act_fire = act_valid && act_ready;
        res_fire = res_valid && res_ready; r_data = res_data;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    q_fid.delete(); q_in0.delete(); q_in1.delete(); q_res.delete();
    rsp_n = 0; act_n = 0; done_cnt = 0; stab_err = 0;
  endtask

  task automatic run_job(input int n, input int f, input logic [31:0] off, input bit hold_emit);
    int k = 0, bad = 0, nc = 0;
    int nn = n > 256 ? 256 : n;
    bit stalled = 0;
    logic [31:0] rd;
    clear_logs();
    res_hold = hold_emit;
    cfg_offset = off; cfg_num_inputs = 9'(n); cfg_num_filters = 8'(f);
    start = 1;
    @(negedge clk);
    start = 0;
    cfg_offset = 32'hFFFF_FFFF; cfg_num_inputs = 9'd7; cfg_num_filters = 8'd9;
    if (nn == 0 || f == 0) check("zero_done", {done, busy}, 2'b10);
    else check("busy_rise", {done, busy}, 2'b01);
    while (!done && k < 20000) begin
      @(negedge clk);
      k++;
      start = (k == 3);
      if (hold_emit && !stalled && res_valid) begin
        rd = res_data; nc = q_fid.size(); bad = 0;
        repeat (20) begin
          @(negedge clk);
          k++;
          if (!res_valid || res_data !== rd || cmd_valid || q_fid.size() != nc) bad++;
        end
        check("emit_stall", bad, 0);
        check("emit_stall_data", rd, 32'hA000 + 32'(2 * nn + 2));
        res_hold = 0;
        stalled = 1;
      end
    end
    start = 0;
    if (hold_emit) check("emit_stall_seen", stalled, 1);
    check("done_seen", done, 1);
    check("done_busy_low", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    @(negedge clk);
    check("done_count", done_cnt, 1);
  endtask

  task automatic check_cmds(input string tag, input int n, input int f, input logic [31:0] off);
    int nn = n > 256 ? 256 : n;
    int tot = (nn == 0 || f == 0) ? 0 : nn + 2 + f * (nn + 1);
    int bad = 0;
    logic [9:0] ef;
    logic [31:0] e0;
    check({tag, "_count"}, q_fid.size(), tot);
    for (int k = 0; k < q_fid.size() && k < tot; k++) begin
      if (k == 0) begin ef = 10'h29; e0 = '0; end
      else if (k == 1) begin ef = 10'h11; e0 = off; end
      else if (k < nn + 2) begin ef = 10'h19; e0 = act_base + 32'(k - 2); end
      else if ((k - nn - 2) % (nn + 1) == 0) begin ef = 10'h09; e0 = '0; end
      else begin ef = 10'h21; e0 = wgt_base; end
      if (q_fid[k] !== ef || q_in0[k] !== e0 || q_in1[k] !== 32'd0) bad++;
    end
    check({tag, "_order"}, bad, 0);
    check({tag, "_stable"}, stab_err, 0);
  endtask

  task automatic check_res(input string tag, input int n, input int f);
    int nn = n > 256 ? 256 : n;
    int bad = 0;
    check({tag, "_res_count"}, q_res.size(), (nn == 0) ? 0 : f);
    for (int i = 0; i < q_res.size() && i < f; i++)
      if (q_res[i] !== 32'hA000 + 32'(2 * nn + 2 + i * (nn + 1))) bad++;
    check({tag, "_res_data"}, bad, 0);
  endtask

  initial begin
    int k, siv, onb;
    repeat (3) @(negedge clk);
    check("reset_ctl", {busy, done, cmd_valid, rsp_ready, act_ready, wgt_ready, res_valid}, 7'd0);
    check("reset_pay", {fid, in0, in1, res_data}, 106'd0);
    reset = 0;
    @(negedge clk);
    stray = 1;
    repeat (3) @(negedge clk);
    check("stray_rsp", {rsp_ready, busy, cmd_valid}, 3'b000);
    stray = 0;
    repeat (4) @(negedge clk);
    check("no_cmd_without_start", q_fid.size(), 0);

    use_tab = 1;
    rsp_tab = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd10, 32'd25, 32'd0};
    act_base = 32'd1; wgt_base = 32'h0101_0101;
    run_job(2, 1, 32'd128, 0);
    check_cmds("basic", 2, 1, 32'd128);
    check("basic_res_count", q_res.size(), 1);
    check("basic_res_25", q_res.size() > 0 ? q_res[0] : 32'hFFFF_FFFF, 32'd25);
    use_tab = 0;

    rand_dly = 1;
    act_base = 32'h10; wgt_base = 32'h0203_0405;
    run_job(3, 2, 32'h55, 0);
    check_cmds("rand", 3, 2, 32'h55);
    check_res("rand", 3, 2);
    rand_dly = 0;

    run_job(0, 3, 32'h1, 0);
    check("zero_n_cmds", q_fid.size(), 0);
    run_job(5, 0, 32'h1, 0);
    check("zero_f_cmds", q_fid.size(), 0);

    act_base = 32'h400; wgt_base = 32'h0A0B_0C0D;
    run_job(300, 2, 32'h77, 0);
    siv = 0; onb = 0;
    foreach (q_fid[i]) begin
      if (q_fid[i] == 10'h19) siv++;
      if (q_fid[i] == 10'h21) onb++;
    end
    check("cap_siv", siv, 256);
    check("cap_onb", onb, 512);
    check_cmds("cap", 300, 2, 32'h77);
    check_res("cap", 300, 2);

    act_base = 32'h30; wgt_base = 32'h1;
    run_job(1, 2, 32'h9, 1);
    check_cmds("stall", 1, 2, 32'h9);
    check_res("stall", 1, 2);

    hold_onb = 1;
    cfg_offset = 32'h5; cfg_num_inputs = 9'd2; cfg_num_filters = 8'd1;
    start = 1;
    @(negedge clk);
    start = 0;
    k = 0;
    while (!(cmd_valid && fid == 10'h21) && k < 500) begin @(negedge clk); k++; end
    check("mid_mac_reached", {cmd_valid, fid}, {1'b1, 10'h21});
    #2 reset = 1;
    #1;
    check("async_ctl", {busy, done, cmd_valid, rsp_ready, act_ready, wgt_ready, res_valid}, 7'd0);
    check("async_pay", {fid, in0, in1, res_data}, 106'd0);
    repeat (2) @(negedge clk);
    hold_onb = 0;
    reset = 0;
    clear_logs();
    repeat (5) @(negedge clk);
    check("post_reset_idle", {busy, cmd_valid, 32'(q_fid.size())}, 34'd0);
    act_base = 32'h60; wgt_base = 32'h7;
    run_job(2, 1, 32'h5, 0);
    check_cmds("after_reset", 2, 1, 32'h5);
    check_res("after_reset", 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
